// File: rtl/shift_unit_seq_if.sv
// Handshake bundle for shift_unit_seq: producer-side request (in_*) and
// consumer-side result (out_*). The producer/consumer side takes the master
// modport and the shift unit takes the slave modport.
interface shift_unit_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_oor;
  logic               out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_oor, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_oor, out_err
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Iterative WIDTH-bit shifter: one bit position per clock, valid/ready on both
// sides. Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
// Optional feature macro: SHIFT_UNIT_ROL_EN. When defined, mode 11 rotates
// left; when undefined, mode 11 is illegal (operand passes through, out_err=1)
// and no rotate datapath is built.
// Amounts above WIDTH-1 (including for ROL) pass the operand through unchanged
// and raise out_oor. Reset is synchronous, active low.
module shift_unit_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_unit_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  localparam int unsigned MAX_SH = WIDTH - 1;

  state_e             state;
  mode_e              mode_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   shift_nxt;
  logic [SHAMT_W-1:0] count;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               oor_q;
  logic               err_q;

  logic accept;
  logic amt_oor;
  logic mode_ill;
  logic pass;

  assign accept  = bus.in_valid && in_ready_q;
  assign amt_oor = 32'(bus.in_shamt) > MAX_SH;
`ifdef SHIFT_UNIT_ROL_EN
  assign mode_ill = 1'b0;
`else
  assign mode_ill = (bus.in_mode == MODE_ROL);
`endif
  // Zero shifts, out-of-range amounts and illegal modes all skip SHIFT.
  assign pass = amt_oor || mode_ill || (bus.in_shamt == '0);

  // Single-bit step of the working register for the latched mode.
  always_comb begin
    // NOTE: default assignment first so every path drives shift_nxt and no latch is inferred.
    shift_nxt = data_q;
    case (mode_q)
      MODE_LSL: shift_nxt = {data_q[WIDTH-2:0], 1'b0};
      MODE_LSR: shift_nxt = {1'b0, data_q[WIDTH-1:1]};
      MODE_ASR: shift_nxt = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROL_EN
      MODE_ROL: shift_nxt = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
      default:  shift_nxt = data_q;
    endcase
  end

  // Control FSM with registered handshake outputs and working register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= MODE_LSL;
      data_q      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      oor_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= bus.in_data;
            mode_q     <= mode_e'(bus.in_mode);
            count      <= bus.in_shamt;
            oor_q      <= amt_oor;
            err_q      <= mode_ill;
            in_ready_q <= 1'b0;
            if (pass) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= shift_nxt;
          count  <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            oor_q       <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_oor   = oor_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=8, SHAMT_W=4). Expected
// results come from an arithmetic reference model of the shift rules.
module tb_shift_unit_seq;

  localparam int W  = 8;
  localparam int SW = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  shift_unit_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: whole-amount shifts with plain operators.
  function automatic void model(input logic [W-1:0] d, input logic [SW-1:0] n,
                                input logic [1:0] m, output logic [W-1:0] r,
                                output logic oor, output logic err,
                                output int lat);
    logic signed [W-1:0] s;
    int amt;
    amt = int'(n);
    s   = d;
    oor = (amt >= W);
`ifdef SHIFT_UNIT_ROL_EN
    err = 1'b0;
`else
    err = (m == 2'b11);
`endif
    if (oor || err || amt == 0) begin
      r   = d;
      lat = 0;
    end else begin
      lat = amt;
      case (m)
        2'b00:   r = d << amt;
        2'b01:   r = d >> amt;
        2'b10:   r = s >>> amt;
        default: r = (d << amt) | (d >> (W - amt));
      endcase
    end
  endfunction

  // Present one request while the unit is idle; returns just after the accept edge.
  task automatic issue(input logic [W-1:0] d, input logic [SW-1:0] n,
                       input logic [1:0] m, input string name);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready_before_accept got=%b want=1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = n;
    bus.in_mode  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, check it and its timing, optionally hold it under
  // backpressure, then optionally release it and check the return to idle.
  task automatic finish_op(input logic [W-1:0] er, input logic eo, input logic ee,
                           input int elat, input int hold, input bit rel,
                           input string name);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc != elat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, cyc, elat);
    end
    total++;
    if (bus.out_data !== er) begin
      bad++;
      $display("FAIL %s out_data got=%h want=%h", name, bus.out_data, er);
    end
    total++;
    if (bus.out_oor !== eo || bus.out_err !== ee) begin
      bad++;
      $display("FAIL %s flags oor/err got=%b%b want=%b%b", name, bus.out_oor,
               bus.out_err, eo, ee);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s in_ready_busy got=%b want=0", name, bus.in_ready);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== er || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold%0d valid/data/ready got=%b/%h/%b want=1/%h/0", name, i,
                 bus.out_valid, bus.out_data, bus.in_ready, er);
      end
    end
    if (rel) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.out_oor !== 1'b0 || bus.out_err !== 1'b0) begin
        bad++;
        $display("FAIL %s release valid/ready/oor/err got=%b/%b/%b/%b want=0/1/0/0",
                 name, bus.out_valid, bus.in_ready, bus.out_oor, bus.out_err);
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] d, input logic [SW-1:0] n,
                        input logic [1:0] m, input int hold, input string name);
    logic [W-1:0] er;
    logic eo, ee;
    int lat;
    model(d, n, m, er, eo, ee, lat);
    issue(d, n, m, name);
    finish_op(er, eo, ee, lat, hold, 1'b1, name);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_oor !== 1'b0 || bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset ready/valid/data/oor/err got=%b/%b/%h/%b/%b want=1/0/00/0/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_oor, bus.out_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(8'hB5, 4'd3, 2'b00, 0, "lsl_b5_3");
    run_op(8'h90, 4'd4, 2'b01, 0, "lsr_90_4");
    run_op(8'h90, 4'd2, 2'b10, 0, "asr_90_2");
    run_op(8'h70, 4'd7, 2'b10, 0, "asr_70_7");
    run_op(8'h81, 4'd7, 2'b00, 0, "lsl_max_amount");
  endtask

  task automatic test_oor_zero();
    run_op(8'hB5, 4'd9,  2'b00, 0, "oor_9");
    run_op(8'hB5, 4'd8,  2'b01, 0, "oor_8");
    run_op(8'hB5, 4'd15, 2'b10, 0, "oor_15");
    run_op(8'hB5, 4'd0,  2'b00, 0, "zero_shift");
  endtask

  task automatic test_backpressure();
    run_op(8'h3C, 4'd2, 2'b00, 5, "backpressure");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] er;
    logic eo, ee;
    int lat;
    issue(8'hFF, 4'd7, 2'b00, "reset_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid ready/valid/data got=%b/%b/%h want=1/0/00",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_mid_quiet%0d valid/ready got=%b/%b want=0/1", i,
                 bus.out_valid, bus.in_ready);
      end
    end
    model(8'h5A, 4'd3, 2'b01, er, eo, ee, lat);
    issue(8'h5A, 4'd3, 2'b01, "after_reset");
    finish_op(er, eo, ee, lat, 0, 1'b1, "after_reset");
  endtask

  task automatic test_mode11();
    run_op(8'h81, 4'd1, 2'b11, 0, "mode11_81_1");
    run_op(8'hC3, 4'd5, 2'b11, 1, "mode11_c3_5");
  endtask

  // A request already waiting while DONE is released is taken one edge later.
  task automatic test_back_to_back();
    logic [W-1:0] er;
    logic eo, ee;
    int lat;
    model(8'h90, 4'd4, 2'b01, er, eo, ee, lat);
    issue(8'h90, 4'd4, 2'b01, "b2b_first");
    finish_op(er, eo, ee, lat, 0, 1'b0, "b2b_first");
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h0F;
    bus.in_shamt  = 4'd2;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_not_taken valid/ready got=%b/%b want=0/1",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model(8'h0F, 4'd2, 2'b00, er, eo, ee, lat);
    finish_op(er, eo, ee, lat, 0, 1'b1, "b2b_second");
  endtask

  task automatic test_random();
    logic [W-1:0]  d;
    logic [SW-1:0] n;
    logic [1:0]    m;
    for (int i = 0; i < 200; i++) begin
      d = W'($urandom);
      n = SW'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      run_op(d, n, m, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_oor_zero();
    test_backpressure();
    test_reset_mid();
    test_mode11();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised, iterative successor to the team's combinational 8-bit logical left shifter.
- Supports WIDTH-bit operands and four shift modes: LSL, LSR, ASR and optional ROL.
- Shifts one bit position per clock, so area stays flat for wide datapaths.
- Sits between a producer and a consumer on valid/ready handshakes; keeps the established out-of-range policy (pass operand through) but reports it with a flag.

Parameters:
- WIDTH, 8: operand/result width in bits; WIDTH >= 2.
- SHAMT_W, 4: shift-amount field width; amounts 0..2^SHAMT_W-1 are accepted.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand/amount/mode presented
- in_ready  output  1  unit can accept; high only in IDLE
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL
- out_valid  output  1  result held; high only in DONE
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_oor  output  1  amount > WIDTH-1; result is the operand unchanged
- out_err  output  1  illegal mode; result is the operand unchanged

Behaviour:
- Reset (rst_n low at a clk edge, any state):
  - state=IDLE; in_ready=1; out_valid=0; out_data=0; out_oor=0; out_err=0; internal count=0.
  - Reset overrides in-flight work; a partially shifted result is discarded and never presented.
- Accept: in_valid && in_ready at an edge latches data, shamt and mode. out_oor/out_err are computed at accept time.
- States:
  - IDLE -> SHIFT if amount n>0, legal mode, n <= WIDTH-1.
  - IDLE -> DONE if n==0, or out-of-range, or illegal mode; operand passes through unchanged.
  - SHIFT -> SHIFT while count>1.
  - SHIFT -> DONE on the edge where count==1.
  - DONE -> IDLE on an edge with out_ready=1.
- Latency: for an accept at edge k, out_valid is high from the cycle after edge k+n for legal shifts, and after edge k for pass-through cases.
- Per SHIFT edge (count decrements by 1):
  - LSL: shift left 1, fill 0.
  - LSR: shift right 1, fill 0.
  - ASR: shift right 1, fill with the MSB.
  - ROL: rotate left 1; the MSB goes to the LSB.
- Output registers:
  - out_data is the working register; it holds its value stable while out_valid=1 and out_ready=0.
  - out_oor/out_err are valid only while out_valid=1 and are cleared on return to IDLE.
- No overlap: in_ready=0 in SHIFT and DONE. in_valid is ignored outside IDLE, and the producer must hold its request.
- Same-edge DONE->IDLE with in_valid high: the new operand is not accepted on that edge (in_ready was 0); it is accepted on the following edge.
- in_shamt with n == WIDTH-1 is legal. n >= WIDTH sets out_oor. This rule applies to ROL too (no modulo).
- No $display or simulation-only side effects in synthesizable code.

Optional Feature:
- Macro: SHIFT_UNIT_ROL_EN.
- Defined: mode 11 performs ROL as above.
- Undefined:
  - Mode 11 is illegal: pass-through, out_err=1, one-cycle path to DONE.
  - The rotate datapath is not built.
- out_err exists in both builds and is constantly 0 for modes 00-10.

Test Plan:
- WIDTH=8, LSL 0xB5 by 3 -> out_data=0xA8, out_oor=0, out_valid first high after accept edge +3.
- LSR 0x90 by 4 -> 0x09. ASR 0x90 by 2 -> 0xE4. ASR 0x70 by 7 -> 0x00.
- Out of range and zero shift:
  - LSL 0xB5 by 9 -> out_data=0xB5, out_oor=1, out_valid right after the accept edge.
  - Amount 0 -> 0xB5, oor=0, same timing.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable and in_ready=0.
  - Then raise out_ready for 1 cycle -> IDLE, in_ready=1.
- Reset mid-operation: start LSL 0xFF by 7, drop rst_n at SHIFT cycle 3 -> next cycle IDLE, out_valid=0, out_data=0; the next op runs correctly.
- Mode 11 on 0x81 by 1:
  - SHIFT_UNIT_ROL_EN defined -> 0x03, out_err=0.
  - Undefined -> 0x81, out_err=1.
